// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: datapath sizes, ALU op codes
// and the layout of one queued ALU result.
package writeback_stage_pkg;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int NREG  = 1 << AW;
    localparam int DEPTH = 2;

    typedef enum logic [0:0] {
        OP_NAND = 1'b0,
        OP_ADD  = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic          we;
        logic          fe;
        logic [AW-1:0] rd;
        logic          c;
        logic          z;
        logic [DW-1:0] o;
    } entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// ALU-result channel, operand read ports and commit observation bus of the
// writeback stage.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_o;
    logic          in_z;
    logic          in_c;
    logic [AW-1:0] in_rd;
    logic          in_we;
    logic          in_fe;
    logic          hold;
    logic [AW-1:0] ra_a;
    logic [DW-1:0] rd_a;
    logic [AW-1:0] ra_b;
    logic [DW-1:0] rd_b;
    logic          flag_z;
    logic          flag_c;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    modport master (
        output in_valid, in_o, in_z, in_c, in_rd, in_we, in_fe, hold, ra_a, ra_b,
        input  in_ready, rd_a, rd_b, flag_z, flag_c, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_o, in_z, in_c, in_rd, in_we, in_fe, hold, ra_a, ra_b,
        output in_ready, rd_a, rd_b, flag_z, flag_c, wb_valid, wb_rd, wb_data
    );

endinterface

// File: rtl/writeback_stage_result_queue.sv
// Two-entry result FIFO. Exposes the head (oldest) and second (newest when
// full) entries so the read ports can forward from both in age order.
module writeback_stage_result_queue
    import writeback_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     din,
    input  logic       pop,
    output logic [1:0] count,
    output entry_t     head,
    output entry_t     second,
    output logic       head_valid,
    output logic       second_valid
);

    logic   rptr;
    logic   wptr;
    entry_t mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= 1'b0;
            wptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload carries no reset: it is only observed through count.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign head         = mem[rptr];
    assign second       = mem[~rptr];
    assign head_valid   = (count != 2'd0);
    assign second_valid = (count == 2'(DEPTH));

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: queues ALU results, commits the head to the register file
// and Z/C flags, and serves two forwarded operand read ports.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    logic          push;
    logic          pop;
    logic [1:0]    count;
    entry_t        din;
    entry_t        head;
    entry_t        second;
    logic          head_valid;
    logic          second_valid;
    logic [DW-1:0] rf [NREG];
    logic          flag_z;
    logic          flag_c;

    // Newer queued producer wins over older; register 0 never forwards.
    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0] ra,
        input entry_t        newer,
        input logic          newer_ok,
        input entry_t        older,
        input logic          older_ok,
        input logic [DW-1:0] rf_val
    );
        logic [DW-1:0] val;
        val = rf_val;
        if (ra == '0)
            val = '0;
        else if (newer_ok && newer.we && newer.rd == ra)
            val = newer.o;
        else if (older_ok && older.we && older.rd == ra)
            val = older.o;
        return val;
    endfunction

    always_comb begin
        din.we = bus.in_we;
        din.fe = bus.in_fe;
        din.rd = bus.in_rd;
        din.c  = bus.in_c;
        din.z  = bus.in_z;
        din.o  = bus.in_o;
    end

    assign bus.in_ready = (count != 2'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = head_valid && !bus.hold;

    writeback_stage_result_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .din          (din),
        .pop          (pop),
        .count        (count),
        .head         (head),
        .second       (second),
        .head_valid   (head_valid),
        .second_valid (second_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (pop && head.we && head.rd != '0) begin
            rf[head.rd] <= head.o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (pop && head.fe) begin
            flag_z <= head.z;
            flag_c <= head.c;
        end
    end

    assign bus.flag_z   = flag_z;
    assign bus.flag_c   = flag_c;
    assign bus.wb_valid = pop;
    assign bus.wb_rd    = pop ? head.rd : '0;
    assign bus.wb_data  = pop ? head.o  : '0;

    assign bus.rd_a = read_port(bus.ra_a, second, second_valid, head, head_valid, rf[bus.ra_a]);
    assign bus.rd_b = read_port(bus.ra_b, second, second_valid, head, head_valid, rf[bus.ra_b]);

endmodule

// File: tb/tb_writeback_stage.sv
// Randomised and directed bench for writeback_stage against a queue-based
// architectural model (pending results list, register array, flags).
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_stage_if bus();

    writeback_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] o;
        bit          z;
        bit          c;
        bit          we;
        bit          fe;
        bit [2:0]    rd;
    } res_t;

    res_t        mq[$];
    logic [15:0] mrf [8];
    bit          mz;
    bit          mc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [2:0] ra);
        if (ra == 3'd0) return 16'h0000;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].we && mq[i].rd == ra) return mq[i].o;
        return mrf[ra];
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0000;
        mz = 1'b0;
        mc = 1'b0;
    endtask

    task automatic put(input bit v, input logic [15:0] o, input bit z, input bit c,
                       input logic [2:0] rd, input bit we, input bit fe, input bit hold,
                       input logic [2:0] ra, input logic [2:0] rb);
        bus.in_valid = v;
        bus.in_o     = o;
        bus.in_z     = z;
        bus.in_c     = c;
        bus.in_rd    = rd;
        bus.in_we    = we;
        bus.in_fe    = fe;
        bus.hold     = hold;
        bus.ra_a     = ra;
        bus.ra_b     = rb;
    endtask

    // Called with clk low and inputs applied; checks, clocks once, updates model.
    task automatic step();
        bit   take;
        bit   commit;
        res_t r;
        res_t h;
        #1;
        commit = (mq.size() > 0) && !bus.hold;
        take   = bus.in_valid && (mq.size() < 2);
        chk("in_ready", bus.in_ready, mq.size() < 2);
        chk("wb_valid", bus.wb_valid, commit);
        chk("wb_rd",    bus.wb_rd,    commit ? mq[0].rd : 3'd0);
        chk("wb_data",  bus.wb_data,  commit ? mq[0].o  : 16'h0);
        chk("rd_a",     bus.rd_a,     model_read(bus.ra_a));
        chk("rd_b",     bus.rd_b,     model_read(bus.ra_b));
        chk("flag_z",   bus.flag_z,   mz);
        chk("flag_c",   bus.flag_c,   mc);
        r = '{o: bus.in_o, z: bus.in_z, c: bus.in_c, we: bus.in_we, fe: bus.in_fe, rd: bus.in_rd};
        @(posedge clk);
        if (commit) begin
            h = mq.pop_front();
            if (h.we && h.rd != 3'd0) mrf[h.rd] = h.o;
            if (h.fe) begin
                mz = h.z;
                mc = h.c;
            end
        end
        if (take) mq.push_back(r);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd0, 3'd0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_wbv",   bus.wb_valid, 0);
        chk("rst_wbd",   bus.wb_data,  0);
        step();

        // Reset with two flag-setting writes parked behind hold.
        put(1, 16'h1111, 1, 1, 3'd1, 1, 1, 1, 3'd1, 3'd2); step();
        put(1, 16'h2222, 1, 1, 3'd2, 1, 1, 1, 3'd1, 3'd2); step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 1, 3'd1, 3'd2);
        #1;
        chk("t1_fwd_a", bus.rd_a, 16'h1111);
        rst = 1'b1;
        #1;
        model_reset();
        bus.hold = 1'b0;
        #1;
        chk("t1_ready", bus.in_ready, 1);
        chk("t1_wbv",   bus.wb_valid, 0);
        chk("t1_rd_a",  bus.rd_a,     0);
        chk("t1_rd_b",  bus.rd_b,     0);
        chk("t1_flagz", bus.flag_z,   0);
        chk("t1_flagc", bus.flag_c,   0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t1_after", bus.rd_b, 0);

        // Back-to-back commits.
        put(1, 16'h1234, 0, 0, 3'd1, 1, 0, 0, 3'd2, 3'd1); step();
        put(1, 16'hFFFF, 0, 1, 3'd2, 1, 1, 0, 3'd2, 3'd1); step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd2, 3'd1); step();
        step();
        chk("t2_r2",    bus.rd_a,   16'hFFFF);
        chk("t2_r1",    bus.rd_b,   16'h1234);
        chk("t2_flagc", bus.flag_c, 1);
        chk("t2_flagz", bus.flag_z, 0);

        // Backpressure: third result waits for the first pop.
        put(1, 16'h4444, 0, 0, 3'd4, 1, 0, 1, 3'd4, 3'd5); step();
        put(1, 16'h5555, 0, 0, 3'd5, 1, 0, 1, 3'd4, 3'd5); step();
        put(1, 16'h6666, 0, 0, 3'd6, 1, 0, 1, 3'd6, 3'd5);
        #1;
        chk("t3_full", bus.in_ready, 0);
        step();
        put(1, 16'h6666, 0, 0, 3'd6, 1, 0, 0, 3'd6, 3'd4); step();
        chk("t3_ready_back", bus.in_ready, 1);
        step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd6, 3'd5);
        step(); step(); step();
        chk("t3_r6", bus.rd_a, 16'h6666);
        chk("t3_r5", bus.rd_b, 16'h5555);

        // Forwarding picks the newest producer.
        put(1, 16'h00AA, 0, 0, 3'd3, 1, 0, 1, 3'd3, 3'd3); step();
        put(1, 16'h0055, 0, 0, 3'd3, 1, 0, 1, 3'd3, 3'd3); step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 1, 3'd3, 3'd3);
        #1;
        chk("t4_fwd", bus.rd_a, 16'h0055);
        step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd3, 3'd3);
        step(); step(); step();
        chk("t4_rf", bus.rd_a, 16'h0055);

        // Register 0 is hardwired.
        put(1, 16'hBEEF, 0, 0, 3'd0, 1, 0, 1, 3'd3, 3'd0); step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 1, 3'd3, 3'd0);
        #1;
        chk("t5_queued", bus.rd_b, 0);
        step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd3, 3'd0);
        step(); step();
        chk("t5_commit", bus.rd_b, 0);

        // Flag-only ADD result.
        put(1, 16'h0000, 1, 1, 3'd7, 0, 1, 0, 3'd7, 3'd2); step();
        put(0, 16'h0, 0, 0, 3'd0, 0, 0, 0, 3'd7, 3'd2);
        step(); step();
        chk("t6_flagz", bus.flag_z, 1);
        chk("t6_flagc", bus.flag_c, 1);
        chk("t6_r7",    bus.rd_a,   0);
        chk("t6_r2",    bus.rd_b,   16'hFFFF);

        for (int n = 0; n < 600; n++) begin
            put($urandom_range(0, 9) < 7, 16'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                3'($urandom), 3'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
